// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage of the 5-stage MIPS pipeline plus the MEM/WB register.
// Holds a DEPTH x 32-bit data memory. Byte, halfword and word stores use
// little-endian lanes. Loads are sign- or zero-extended by opcode and registered.
// A flush inserts a bubble and a stall holds the register; both suppress stores.
// Optional feature macro: MISALIGN_TRAP_EN.
//   Defined   : a misaligned half or word access is trapped. The store is dropped,
//               RegWrite_q is cleared and misalign_q is set.
//   Undefined : the low address bits are forced to the natural alignment of the access.
module mem_wb_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] addr_d,
  input  logic [31:0] result_d,
  input  logic [31:0] rt_data_d,
  input  logic [5:0]  opcode_d,
  input  logic [4:0]  rd_d,
  input  logic        MemWrite_d,
  input  logic        MemRead_d,
  input  logic        MemtoReg_d,
  input  logic        RegWrite_d,
  output logic [31:0] mem_data_q,
  output logic [31:0] result_q,
  output logic [4:0]  rd_q,
  output logic        MemtoReg_q,
  output logic        RegWrite_q,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_q,
`endif
  output logic [31:0] wb_data
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [31:0]       mem_r [0:DEPTH-1];

  logic [ADDR_W-1:0] idx_s;
  logic [1:0]        size_s;
  logic              access_s;
  logic [1:0]        off_s;
  logic              misalign_s;
  logic              store_en_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic [31:0]       rdata_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [31:0]       load_ext_s;
  logic              unused_addr_s;

  // Address bits above the word index are ignored, so accesses wrap modulo DEPTH*4.
  assign idx_s         = addr_d[ADDR_W+1:2];
  assign unused_addr_s = ^addr_d[31:ADDR_W+2];
  assign access_s      = MemWrite_d | MemRead_d;

  // Work out the access size. A store is sized by the store opcodes and a load by the load opcodes.
  always_comb begin
    size_s = SZ_W;
    if (MemWrite_d) begin
      case (opcode_d)
        OP_SB:   size_s = SZ_B;
        OP_SH:   size_s = SZ_H;
        default: size_s = SZ_W;
      endcase
    end else begin
      case (opcode_d)
        OP_LB, OP_LBU: size_s = SZ_B;
        OP_LH, OP_LHU: size_s = SZ_H;
        default:       size_s = SZ_W;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Flag a half or word access whose low address bits do not match the access size.
  always_comb begin
    off_s      = addr_d[1:0];
    misalign_s = 1'b0;
    case (size_s)
      SZ_H:    misalign_s = access_s & addr_d[0];
      SZ_W:    misalign_s = access_s & (addr_d[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
  end
`else
  // Force the low address bits to the natural alignment of the access.
  always_comb begin
    off_s = addr_d[1:0];
    case (size_s)
      SZ_H:    off_s = {addr_d[1], 1'b0};
      SZ_W:    off_s = 2'b00;
      default: off_s = addr_d[1:0];
    endcase
  end
  assign misalign_s = 1'b0;
`endif

  // A store commits only on an unstalled, unflushed and non-trapping cycle.
  assign store_en_s = MemWrite_d & ~stall & ~flush & ~misalign_s;

  // Build the byte-lane enables and replicate the store data across the lanes.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = rt_data_d;
    case (size_s)
      SZ_B: begin
        be_s    = 4'b0001 << off_s;
        wdata_s = {4{rt_data_d[7:0]}};
      end
      SZ_H: begin
        be_s    = off_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{rt_data_d[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = rt_data_d;
      end
    endcase
  end

  // Data memory write port. It has no reset, and lanes not selected keep their contents.
  always_ff @(posedge clk) begin
    if (reset && store_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Asynchronous read. A read and a write to the same word in one cycle returns the old contents.
  assign rdata_s = mem_r[idx_s];

  // Select the addressed byte and halfword lanes of the word that was read.
  always_comb begin
    byte_s = rdata_s[7:0];
    case (off_s)
      2'd0:    byte_s = rdata_s[7:0];
      2'd1:    byte_s = rdata_s[15:8];
      2'd2:    byte_s = rdata_s[23:16];
      2'd3:    byte_s = rdata_s[31:24];
      default: byte_s = rdata_s[7:0];
    endcase
    half_s = off_s[1] ? rdata_s[31:16] : rdata_s[15:0];
  end

  // Extend the loaded data by opcode. The result is zero when there is no load or the load traps.
  always_comb begin
    load_ext_s = rdata_s;
    case (opcode_d)
      OP_LB:   load_ext_s = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  load_ext_s = {24'h000000, byte_s};
      OP_LH:   load_ext_s = {{16{half_s[15]}}, half_s};
      OP_LHU:  load_ext_s = {16'h0000, half_s};
      default: load_ext_s = rdata_s;
    endcase
    if (!MemRead_d || misalign_s) begin
      load_ext_s = 32'h0000_0000;
    end else begin
      load_ext_s = load_ext_s;
    end
  end

  // MEM/WB register. Priority is reset, then flush (bubble), then stall (hold), then normal load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_data_q <= 32'h0000_0000;
      result_q   <= 32'h0000_0000;
      rd_q       <= 5'd0;
      MemtoReg_q <= 1'b0;
      RegWrite_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else if (flush) begin
      mem_data_q <= 32'h0000_0000;
      result_q   <= 32'h0000_0000;
      rd_q       <= 5'd0;
      MemtoReg_q <= 1'b0;
      RegWrite_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else if (stall) begin
      mem_data_q <= mem_data_q;
      result_q   <= result_q;
      rd_q       <= rd_q;
      MemtoReg_q <= MemtoReg_q;
      RegWrite_q <= RegWrite_q;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_q;
`endif
    end else begin
      mem_data_q <= load_ext_s;
      result_q   <= result_d;
      rd_q       <= rd_d;
      MemtoReg_q <= MemtoReg_d;
      RegWrite_q <= RegWrite_d & ~misalign_s;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_s;
`endif
    end
  end

  // Write-back mux between the loaded data and the ALU result.
  assign wb_data = MemtoReg_q ? mem_data_q : result_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage. It covers stores and loads of every width,
// extension, stall, flush, address wrap, alignment handling and asynchronous reset.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] addr_d;
  logic [31:0] result_d;
  logic [31:0] rt_data_d;
  logic [5:0]  opcode_d;
  logic [4:0]  rd_d;
  logic        MemWrite_d;
  logic        MemRead_d;
  logic        MemtoReg_d;
  logic        RegWrite_d;
  logic [31:0] mem_data_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;
  logic        MemtoReg_q;
  logic        RegWrite_q;
  logic [31:0] wb_data;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_q;
`endif

  int errors = 0;
  int checks = 0;

  mem_wb_stage #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .addr_d(addr_d), .result_d(result_d), .rt_data_d(rt_data_d),
    .opcode_d(opcode_d), .rd_d(rd_d),
    .MemWrite_d(MemWrite_d), .MemRead_d(MemRead_d),
    .MemtoReg_d(MemtoReg_d), .RegWrite_d(RegWrite_d),
    .mem_data_q(mem_data_q), .result_q(result_q), .rd_q(rd_q),
    .MemtoReg_q(MemtoReg_q), .RegWrite_q(RegWrite_q),
`ifdef MISALIGN_TRAP_EN
    .misalign_q(misalign_q),
`endif
    .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic re, input logic m2r, input logic rw,
                       input logic [4:0] rd, input logic [31:0] res);
    opcode_d = op; addr_d = a; rt_data_d = d;
    MemWrite_d = we; MemRead_d = re; MemtoReg_d = m2r; RegWrite_d = rw;
    rd_d = rd; result_d = res;
  endtask

  task automatic idle();
    drive(6'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    idle();
    step();
    checks++; if (mem_data_q !== 32'h0) begin errors++; $display("FAIL reset_mem_data got=%h exp=%h", mem_data_q, 32'h0); end
    checks++; if (result_q !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=%h", result_q, 32'h0); end
    checks++; if ({rd_q, MemtoReg_q, RegWrite_q} !== 7'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", {rd_q, MemtoReg_q, RegWrite_q}); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb got=%h exp=%h", wb_data, 32'h0); end
    reset = 1'b1;
  endtask

  task automatic test_sw_lw();
    drive(6'h2B, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h10);
    step();
    drive(6'h23, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'h10);
    step();
    checks++; if (mem_data_q !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_lw_data got=%h exp=%h", mem_data_q, 32'hDEADBEEF); end
    checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_lw_wb got=%h exp=%h", wb_data, 32'hDEADBEEF); end
    checks++; if (rd_q !== 5'd5 || RegWrite_q !== 1'b1) begin errors++; $display("FAIL sw_lw_ctrl got rd=%0d rw=%b exp rd=5 rw=1", rd_q, RegWrite_q); end
  endtask

  task automatic test_byte();
    drive(6'h2B, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    drive(6'h28, 32'h21, 32'h12345680, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    drive(6'h20, 32'h21, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got=%h exp=%h", mem_data_q, 32'hFFFFFF80); end
    drive(6'h24, 32'h21, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'h00000080) begin errors++; $display("FAIL lbu got=%h exp=%h", mem_data_q, 32'h00000080); end
    drive(6'h23, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'h00008000) begin errors++; $display("FAIL lw_after_sb got=%h exp=%h", mem_data_q, 32'h00008000); end
  endtask

  task automatic test_half();
    drive(6'h2B, 32'h30, 32'hAAAA8765, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    drive(6'h29, 32'h32, 32'hFFFF1234, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    drive(6'h25, 32'h32, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'h00001234) begin errors++; $display("FAIL lhu got=%h exp=%h", mem_data_q, 32'h00001234); end
    drive(6'h21, 32'h30, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'hFFFF8765) begin errors++; $display("FAIL lh_low got=%h exp=%h", mem_data_q, 32'hFFFF8765); end
    drive(6'h23, 32'h30, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'h12348765) begin errors++; $display("FAIL lw_after_sh got=%h exp=%h", mem_data_q, 32'h12348765); end
  endtask

  task automatic test_no_read();
    drive(6'h23, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h13572468);
    step();
    checks++; if (mem_data_q !== 32'h0) begin errors++; $display("FAIL noread_data got=%h exp=%h", mem_data_q, 32'h0); end
    checks++; if (wb_data !== 32'h13572468) begin errors++; $display("FAIL noread_wb got=%h exp=%h", wb_data, 32'h13572468); end
  endtask

  task automatic test_stall();
    drive(6'h23, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0000ABCD);
    step();
    stall = 1'b1;
    drive(6'h2B, 32'h10, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'hDEADBEEF || result_q !== 32'h0000ABCD) begin errors++; $display("FAIL stall_hold_data got=%h/%h exp=%h/%h", mem_data_q, result_q, 32'hDEADBEEF, 32'h0000ABCD); end
    checks++; if (rd_q !== 5'd7 || MemtoReg_q !== 1'b1 || RegWrite_q !== 1'b1) begin errors++; $display("FAIL stall_hold_ctrl got rd=%0d m2r=%b rw=%b exp 7/1/1", rd_q, MemtoReg_q, RegWrite_q); end
    stall = 1'b0;
    drive(6'h23, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_no_store got=%h exp=%h", mem_data_q, 32'hDEADBEEF); end
  endtask

  task automatic test_flush();
    stall = 1'b1; flush = 1'b1;
    drive(6'h2B, 32'h10, 32'h22222222, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h55AA55AA);
    step();
    checks++; if (mem_data_q !== 32'h0 || result_q !== 32'h0 || wb_data !== 32'h0) begin errors++; $display("FAIL flush_data got=%h/%h/%h exp=0", mem_data_q, result_q, wb_data); end
    checks++; if ({rd_q, MemtoReg_q, RegWrite_q} !== 7'h0) begin errors++; $display("FAIL flush_ctrl got=%h exp=0", {rd_q, MemtoReg_q, RegWrite_q}); end
    stall = 1'b0; flush = 1'b0;
    drive(6'h23, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'hDEADBEEF) begin errors++; $display("FAIL flush_no_store got=%h exp=%h", mem_data_q, 32'hDEADBEEF); end
  endtask

  task automatic test_wrap();
    drive(6'h2B, 32'h400, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    drive(6'h23, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_word0 got=%h exp=%h", mem_data_q, 32'hCAFEF00D); end
    drive(6'h23, 32'h800, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_read got=%h exp=%h", mem_data_q, 32'hCAFEF00D); end
  endtask

  task automatic test_misalign();
    drive(6'h2B, 32'h13, 32'h55555555, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0);
    step();
`ifdef MISALIGN_TRAP_EN
    checks++; if (misalign_q !== 1'b1 || RegWrite_q !== 1'b0) begin errors++; $display("FAIL mis_sw_flag got mis=%b rw=%b exp 1/0", misalign_q, RegWrite_q); end
`else
    checks++; if (RegWrite_q !== 1'b1) begin errors++; $display("FAIL mis_sw_rw got=%b exp=1", RegWrite_q); end
`endif
    drive(6'h25, 32'h33, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0);
    step();
`ifdef MISALIGN_TRAP_EN
    checks++; if (misalign_q !== 1'b1 || RegWrite_q !== 1'b0) begin errors++; $display("FAIL mis_lh_flag got mis=%b rw=%b exp 1/0", misalign_q, RegWrite_q); end
`else
    checks++; if (mem_data_q !== 32'h00001234) begin errors++; $display("FAIL mis_lhu_align got=%h exp=%h", mem_data_q, 32'h00001234); end
`endif
    drive(6'h23, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0);
    step();
`ifdef MISALIGN_TRAP_EN
    checks++; if (mem_data_q !== 32'hDEADBEEF || misalign_q !== 1'b0) begin errors++; $display("FAIL mis_sw_suppressed got=%h mis=%b exp=%h mis=0", mem_data_q, misalign_q, 32'hDEADBEEF); end
`else
    checks++; if (mem_data_q !== 32'h55555555) begin errors++; $display("FAIL mis_sw_aligned got=%h exp=%h", mem_data_q, 32'h55555555); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(6'h23, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h9999);
    step();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (mem_data_q !== 32'h0 || result_q !== 32'h0 || wb_data !== 32'h0) begin errors++; $display("FAIL async_reset_data got=%h/%h/%h exp=0", mem_data_q, result_q, wb_data); end
    checks++; if ({rd_q, MemtoReg_q, RegWrite_q} !== 7'h0) begin errors++; $display("FAIL async_reset_ctrl got=%h exp=0", {rd_q, MemtoReg_q, RegWrite_q}); end
    idle();
    step();
    #2;
    reset = 1'b1;
    drive(6'h23, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h0);
    step();
    checks++; if (mem_data_q !== 32'h00008000) begin errors++; $display("FAIL mem_kept_after_reset got=%h exp=%h", mem_data_q, 32'h00008000); end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_no_read();
    test_stall();
    test_flush();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register.
- Holds the data memory and performs byte, halfword and word loads and stores, with load extension selected by opcode.
- Registers the results into the MEM/WB pipeline register that feeds write-back.
- Supports pipeline stall (hold) and flush (bubble insertion).

Parameters:
- DEPTH, 256, number of 32-bit words in the data memory; power of two.
- ADDR_W, 8, word-index width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- stall  input  1  hold MEM/WB contents; suppress store
- flush  input  1  load bubble into MEM/WB; suppress store
- addr_d  input  32  byte address from EX/MEM (ALU result)
- result_d  input  32  ALU result passed to write-back
- rt_data_d  input  32  store data
- opcode_d  input  6  instruction opcode; selects access size and sign handling
- rd_d  input  5  destination register
- MemWrite_d  input  1  store enable
- MemRead_d  input  1  load enable
- MemtoReg_d  input  1  write-back select
- RegWrite_d  input  1  register-file write enable
- mem_data_q  output  32  extended load data
- result_q  output  32  registered ALU result
- rd_q  output  5  registered destination
- MemtoReg_q  output  1  registered write-back select
- RegWrite_q  output  1  registered write enable
- wb_data  output  32  combinational: mem_data_q if MemtoReg_q, else result_q
- misalign_q  output  1  registered misaligned-access flag (present only with the optional feature)

Behaviour:
- Reset is asynchronous, active-low, on clk/reset as decided. All registered outputs clear to 0. Memory contents are not cleared.
- Word index is addr_d[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Byte lanes are little-endian: byte offset 0 maps to bits [7:0]; halfword offset 0 maps to bits [15:0], offset 2 to bits [31:16].
- Stores take effect at posedge when MemWrite_d=1, stall=0, flush=0 and reset is high:
  - SB (0x28) writes rt_data_d[7:0] to lane addr_d[1:0].
  - SH (0x29) writes rt_data_d[15:0] to the half at addr_d[1].
  - SW (0x2B) writes the full word.
  - Any other opcode with MemWrite_d=1 writes the full word.
  - Unwritten lanes are preserved.
- Loads read memory combinationally in the same cycle and are extended before registering. Latency from EX/MEM to MEM/WB is 1 cycle.
  - LB 0x20: sign-extend the byte.
  - LBU 0x24: zero-extend the byte.
  - LH 0x21: sign-extend the half.
  - LHU 0x25: zero-extend the half.
  - LW 0x23, or any other opcode: the full word.
- If MemRead_d=0, mem_data_q loads 0.
- Read-during-write to the same word in one cycle is not a legal pipeline case. If it occurs, the load returns the old contents.
- Priority at posedge: reset > flush > stall > normal.
  - flush: all MEM/WB registers load 0 (bubble); no store.
  - stall: all MEM/WB registers hold; no store.
  - normal: registers load the next values.
- flush and stall asserted together: flush wins.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access is a halfword access with addr_d[0]=1, or a word access with addr_d[1:0]≠0.
  - On a misaligned access the store is suppressed, RegWrite_q loads 0, and misalign_q loads 1 for that instruction.
  - misalign_q follows the same flush/stall/reset rules as the other registers.
- Undefined:
  - The misalign_q port is absent.
  - Low address bits are forced to alignment: bit 0 cleared for halfword accesses, bits [1:0] cleared for word accesses.
  - The access then proceeds normally.

Test Plan:
- Reset mid-operation after nonzero traffic: pull reset low -> all outputs 0 asynchronously, before the next edge. Release, then LW of a previously stored word -> the stored value is intact.
- SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> mem_data_q=0xDEADBEEF and wb_data=0xDEADBEEF with MemtoReg=1, one cycle after the load is presented.
- SB 0x80 to 0x21, then LB 0x21 -> 0xFFFFFF80. LBU 0x21 -> 0x00000080. LW 0x20 -> 0x00008000 (word previously zeroed).
- SH 0x1234 to 0x32, then LHU 0x32 -> 0x00001234. LH 0x30 -> the preserved lower half.
- Store with stall=1 -> memory unchanged and outputs hold. Store with flush=1 and stall=1 -> memory unchanged and outputs 0. Address 0x400 with DEPTH=256 -> wraps to word 0.
- SW to 0x13:
  - With MISALIGN_TRAP_EN: misalign_q=1, RegWrite_q=0, memory unchanged.
  - Without it: the write lands at 0x10.
